// File: rtl/rv32_div_ctrl.sv
// rv32_div_ctrl: radix-2 restoring DIV/DIVU/REM/REMU sequencer; RV32_DIV_EARLY_OUT_EN enables special-case early out
module rv32_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] rs1_value_in,
  input  logic [WIDTH-1:0] rs2_value_in,
  input  logic             flush_in,
  output logic             stall_out,
  output logic             ready_out,
  output logic [WIDTH-1:0] result_out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] quo, rem, dvs, abs_a, abs_b, quo_n, rem_n, fin, early_res;
  logic [WIDTH:0] rem_ext, diff;
  logic [CW-1:0] cnt;
  logic op_rem, neg_q, neg_r, accept, sgn, a_neg, b_neg, last, early, no_borrow;
  assign accept = state == IDLE && start_in && !flush_in;
  assign sgn = !op_in[0];
  assign a_neg = sgn && rs1_value_in[WIDTH-1];
  assign b_neg = sgn && rs2_value_in[WIDTH-1];
  assign abs_a = a_neg ? -rs1_value_in : rs1_value_in;
  assign abs_b = b_neg ? -rs2_value_in : rs2_value_in;
  assign rem_ext = {rem, quo[WIDTH-1]};
  assign diff = rem_ext - {1'b0, dvs};
  assign no_borrow = !diff[WIDTH];
  assign rem_n = no_borrow ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], no_borrow};
  assign fin = op_rem ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
  assign last = cnt == '0;
`ifdef RV32_DIV_EARLY_OUT_EN
  assign early = rs2_value_in == '0 ||
                 (sgn && rs1_value_in == {1'b1, {(WIDTH-1){1'b0}}} && rs2_value_in == '1);
  assign early_res = rs2_value_in == '0 ? (op_in[1] ? rs1_value_in : '1)
                                        : (op_in[1] ? '0 : rs1_value_in);
`else
  assign early = 1'b0;
  assign early_res = '0;
`endif
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // next state and handshake outputs; flush wins everywhere
  always_comb begin
    state_nxt = flush_in ? IDLE :
                state == IDLE ? (accept ? (early ? DONE : RUN) : IDLE) :
                state == RUN ? (last ? DONE : RUN) : IDLE;
    stall_out = accept || state == RUN;
    ready_out = state == DONE;
  end
  // operand capture, shift/subtract iteration, and signed result fix-up on the final step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      op_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result_out <= '0;
    end else if (accept) begin
      op_rem <= op_in[1];
      neg_q <= (a_neg ^ b_neg) && rs2_value_in != '0;
      neg_r <= a_neg;
      quo <= abs_a;
      rem <= '0;
      dvs <= abs_b;
      cnt <= CW'(WIDTH - 1);
      if (early) result_out <= early_res;
    end else if (state == RUN && !flush_in) begin
      quo <= quo_n;
      rem <= rem_n;
      cnt <= cnt - 1'b1;
      if (last) result_out <= fin;
    end
  end
endmodule

// File: tb/tb_rv32_div_ctrl.sv
// tb_rv32_div_ctrl: scoreboard bench for the divide sequencer with directed vectors
module tb_rv32_div_ctrl;
  localparam int W = 32;
  localparam int FL = 33;
`ifdef RV32_DIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 33;
`endif
  logic clk = 1'b0;
  logic reset, start_in, flush_in, stall_out, ready_out;
  logic [1:0] op_in;
  logic [W-1:0] rs1, rs2, result_out;
  typedef struct {
    logic [W-1:0] res;
    int cyc;
    string name;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int stall_hi = 0;
  int s0;

  rv32_div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_in(start_in), .op_in(op_in),
    .rs1_value_in(rs1), .rs2_value_in(rs2), .flush_in(flush_in),
    .stall_out(stall_out), .ready_out(ready_out), .result_out(result_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every ready pulse must match the oldest queued expectation, in value and cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (stall_out) stall_hi++;
    if (!reset && ready_out) begin
      if (q.size() == 0) chk("spurious_ready", 32'(ready_out), 32'd0);
      else begin
        e = q.pop_front();
        chk({e.name, "_res"}, result_out, e.res);
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // issue one op in the current (IDLE) cycle and wait for the monitor to drain it
  task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e, input int lat);
    exp_t x;
    start_in = 1'b1;
    op_in = op;
    rs1 = a;
    rs2 = b;
    x.res = e;
    x.cyc = cyc + lat;
    x.name = nm;
    q.push_back(x);
    @(negedge clk);
    chk({nm, "_stall_start"}, 32'(stall_out), 32'd1);
    @(posedge clk); #1;
    start_in = 1'b0;
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      chk({nm, "_timeout"}, 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start_in = 1'b0;
    flush_in = 1'b0;
    op_in = 2'b00;
    rs1 = '0;
    rs2 = '0;
    #1;
    chk("rst_result", result_out, 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    start_in = 1'b1;
    #1;
    chk("rst_stall_start", 32'(stall_out), 32'd1);
    start_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    s0 = stall_hi;
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, FL);
    chk("divu_stall_cycles", 32'(stall_hi - s0), 32'd33);
    run_op("rem_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, FL);
    run_op("div_m7_2", 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, FL);
    run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, FL);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, FL);
    run_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, EL);
    run_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, EL);
    run_op("divu_by0", 2'b01, 32'd1234, 32'd0, 32'hFFFFFFFF, EL);
    run_op("remu_by0", 2'b11, 32'd1234, 32'd0, 32'd1234, EL);
    run_op("div_m5_by0", 2'b00, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, EL);
    run_op("rem_m5_by0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, EL);
    run_op("divu_max_1", 2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, FL);
    run_op("remu_big", 2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, FL);

    s0 = stall_hi;
    start_in = 1'b1;
    op_in = 2'b01;
    rs1 = 32'd1000;
    rs2 = 32'd3;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    chk("flush_stall", 32'(stall_out), 32'd0);
    chk("flush_result_held", result_out, 32'h7FFFFFFE);
    chk("flush_stall_cycles", 32'(stall_hi - s0), 32'd11);
    repeat (40) @(posedge clk);
    #1;

    start_in = 1'b1;
    flush_in = 1'b1;
    #1;
    chk("flush_beats_start", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    start_in = 1'b0;
    flush_in = 1'b0;
    chk("flush_start_idle", 32'(stall_out), 32'd0);
    repeat (40) @(posedge clk);
    #1;

    start_in = 1'b1;
    rs1 = 32'd1000;
    rs2 = 32'd3;
    op_in = 2'b01;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_result", result_out, 32'd0);
    chk("async_rst_ready", 32'(ready_out), 32'd0);
    chk("async_rst_stall", 32'(stall_out), 32'd0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, FL);
    run_op("remu_b2b", 2'b11, 32'd10, 32'd3, 32'd1, FL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
